demux14_stream: RTL and testbench

//  1-to-4 distributor; the inverse of the 4:1 operand mux. Accepts a stream of

---
 rtl/demux14_stream.sv | 106 ++++++++++
 tb/tb_demux14_stream.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demux14_stream.sv
// 1-to-4 stream distributor: steers each accepted element into one of four lane
// holding registers (explicit or round-robin select) and pulses done once drained.
module demux14_stream #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [CNT_W-1:0]   vlen,
    input  logic               auto_sel,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] vlen_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             auto_q;
    logic [1:0]       rr;
    logic [1:0]       lane;
    logic             accept;

    // A lane can take a new element if it is empty or being drained this cycle.
    always_comb begin
        lane     = auto_q ? rr : in_sel;
        in_ready = (state == RUN) & (~out_valid[lane] | out_ready[lane]);
        accept   = in_valid & in_ready;
        busy     = (state != IDLE);
        cnt_next = cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            vlen_q <= '0;
            auto_q <= 1'b0;
            cnt    <= '0;
            rr     <= 2'd0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (vlen != '0) begin
                            vlen_q <= vlen;
                            auto_q <= auto_sel;
                            cnt    <= '0;
                            rr     <= 2'd0;
                            state  <= RUN;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        cnt <= cnt_next;
                        if (auto_q) rr <= rr + 2'd1;
                        if (cnt_next == vlen_q) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_valid == 4'b0000) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reload wins over drain so a lane can sustain one element per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (accept && lane == 2'(i)) begin
                    out_data[i*WIDTH +: WIDTH] <= in_data;
                    out_valid[i]               <= 1'b1;
                end else if (out_valid[i] && out_ready[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_demux14_stream.sv
// Directed self-checking bench for demux14_stream with hand-computed expectations.
module tb_demux14_stream;

    localparam int WIDTH = 16;
    localparam int CNT_W = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [CNT_W-1:0]   vlen;
    logic               auto_sel;
    logic [WIDTH-1:0]   in_data;
    logic [1:0]         in_sel;
    logic               in_valid;
    logic               in_ready;
    logic [4*WIDTH-1:0] out_data;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic               busy;
    logic               done;

    int compared   = 0;
    int mismatched = 0;
    int accepts    = 0;
    int done_count = 0;
    int acc_base;
    int done_base;

    demux14_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .vlen      (vlen),
        .auto_sel  (auto_sel),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Handshakes and done pulses are tallied mid-cycle, where everything is settled.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) accepts++;
        if (rst_n && done) done_count++;
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 20) begin
            cycle();
            n++;
        end
        check_output(tag, 64'(done), 64'd1);
    endtask

    function automatic logic [WIDTH-1:0] lane_of(input int i);
        return out_data[i*WIDTH +: WIDTH];
    endfunction

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        vlen      = '0;
        auto_sel  = 1'b0;
        in_data   = '0;
        in_sel    = 2'd0;
        in_valid  = 1'b0;
        out_ready = 4'h0;
        cycle();
        cycle();
        check_output("rst_busy", 64'(busy), 64'd0);
        check_output("rst_out_valid", 64'(out_valid), 64'd0);
        check_output("rst_out_data", 64'(out_data), 64'd0);
        check_output("rst_done", 64'(done), 64'd0);
        check_output("rst_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        cycle();

        // Reset in the middle of a transfer with two lanes holding data.
        start = 1'b1; vlen = 8'd5; auto_sel = 1'b1;
        cycle();
        start = 1'b0;
        check_output("t1_busy", 64'(busy), 64'd1);
        in_valid = 1'b1; in_data = 16'hAAAA;
        #1;
        check_output("t1_in_ready", 64'(in_ready), 64'd1);
        cycle();
        in_data = 16'hBBBB;
        cycle();
        in_valid = 1'b0;
        check_output("t1_two_full", 64'(out_valid), 64'h3);
        check_output("t1_lane1_data", 64'(lane_of(1)), 64'hBBBB);
        rst_n = 1'b0;
        #1;
        check_output("t1_rst_valid", 64'(out_valid), 64'd0);
        check_output("t1_rst_busy", 64'(busy), 64'd0);
        check_output("t1_rst_data", 64'(out_data), 64'd0);
        cycle();
        check_output("t1_rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        cycle();
        check_output("t1_after_done", 64'(done), 64'd0);

        // Round-robin, full throughput, six elements.
        acc_base = accepts; done_base = done_count;
        out_ready = 4'hF;
        start = 1'b1; vlen = 8'd6; auto_sel = 1'b1;
        cycle();
        start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            in_valid = 1'b1; in_data = 16'(k);
            #1;
            check_output($sformatf("t2_in_ready_%0d", k), 64'(in_ready), 64'd1);
            cycle();
            check_output($sformatf("t2_lane_valid_%0d", k), 64'(out_valid),
                         64'(4'b0001 << ((k - 1) % 4)));
            check_output($sformatf("t2_lane_data_%0d", k), 64'(lane_of((k - 1) % 4)),
                         64'(k));
        end
        in_valid = 1'b0;
        check_output("t2_drain_busy", 64'(busy), 64'd1);
        cycle();
        check_output("t2_drained", 64'(out_valid), 64'd0);
        check_output("t2_done_early", 64'(done), 64'd0);
        cycle();
        check_output("t2_done", 64'(done), 64'd1);
        check_output("t2_idle", 64'(busy), 64'd0);
        cycle();
        check_output("t2_done_pulse", 64'(done), 64'd0);
        check_output("t2_accepts", 64'(accepts - acc_base), 64'd6);
        check_output("t2_done_count", 64'(done_count - done_base), 64'd1);

        // Explicit lane 2 with backpressure, then resume.
        acc_base = accepts; done_base = done_count;
        out_ready = 4'b1011;
        start = 1'b1; vlen = 8'd4; auto_sel = 1'b0;
        cycle();
        start = 1'b0;
        in_sel = 2'd2; in_valid = 1'b1; in_data = 16'h0031;
        #1;
        check_output("t3_first_ready", 64'(in_ready), 64'd1);
        cycle();
        in_data = 16'h0032;
        #1;
        check_output("t3_stalled", 64'(in_ready), 64'd0);
        cycle();
        check_output("t3_hold_valid", 64'(out_valid), 64'h4);
        check_output("t3_hold_data", 64'(lane_of(2)), 64'h0031);
        out_ready = 4'hF;
        #1;
        check_output("t3_resume", 64'(in_ready), 64'd1);
        cycle();
        check_output("t3_data_32", 64'(lane_of(2)), 64'h0032);
        in_data = 16'h0033;
        cycle();
        check_output("t3_data_33", 64'(lane_of(2)), 64'h0033);
        in_data = 16'h0034;
        cycle();
        check_output("t3_data_34", 64'(lane_of(2)), 64'h0034);
        check_output("t3_valid_34", 64'(out_valid), 64'h4);
        in_valid = 1'b0;
        wait_done("t3_done");
        check_output("t3_accepts", 64'(accepts - acc_base), 64'd4);
        cycle();

        // Empty transfer.
        done_base = done_count;
        start = 1'b1; vlen = 8'd0;
        #1;
        check_output("t4_in_ready", 64'(in_ready), 64'd0);
        cycle();
        start = 1'b0;
        check_output("t4_done", 64'(done), 64'd1);
        check_output("t4_busy", 64'(busy), 64'd0);
        cycle();
        check_output("t4_done_pulse", 64'(done), 64'd0);
        check_output("t4_still_idle", 64'(busy), 64'd0);
        check_output("t4_done_count", 64'(done_count - done_base), 64'd1);

        // A second start during RUN must not disturb the running transfer.
        acc_base = accepts; done_base = done_count;
        start = 1'b1; vlen = 8'd3; auto_sel = 1'b1;
        cycle();
        vlen = 8'd9;
        in_valid = 1'b1; in_data = 16'h0051;
        cycle();
        start = 1'b0;
        in_data = 16'h0052;
        cycle();
        in_data = 16'h0053;
        cycle();
        check_output("t5_lane2", 64'(lane_of(2)), 64'h0053);
        #1;
        check_output("t5_drain_ready", 64'(in_ready), 64'd0);
        wait_done("t5_done");
        in_valid = 1'b0;
        cycle();
        cycle();
        check_output("t5_busy", 64'(busy), 64'd0);
        check_output("t5_accepts", 64'(accepts - acc_base), 64'd3);
        check_output("t5_done_count", 64'(done_count - done_base), 64'd1);

        // Simultaneous drain and reload of lane 1.
        acc_base = accepts;
        out_ready = 4'h0;
        start = 1'b1; vlen = 8'd3; auto_sel = 1'b0;
        cycle();
        start = 1'b0;
        in_sel = 2'd1; in_valid = 1'b1; in_data = 16'h0061;
        cycle();
        check_output("t6_first", 64'(lane_of(1)), 64'h0061);
        out_ready = 4'b0010; in_data = 16'h0062;
        #1;
        check_output("t6_ready", 64'(in_ready), 64'd1);
        cycle();
        check_output("t6_valid_kept", 64'(out_valid), 64'h2);
        check_output("t6_new_data", 64'(lane_of(1)), 64'h0062);
        in_data = 16'h0063;
        cycle();
        check_output("t6_third", 64'(lane_of(1)), 64'h0063);
        #1;
        check_output("t6_drain_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        wait_done("t6_done");
        check_output("t6_accepts", 64'(accepts - acc_base), 64'd3);
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
